// File: rtl/reg_file_2w_sb.sv
// Dual-write, dual-read register file with optional write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module reg_file_2w_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we0_in,
   input  logic [ADDR_WIDTH-1:0] waddr0_in,
   input  logic [DATA_WIDTH-1:0] wdata0_in,
   input  logic                  we1_in,
   input  logic [ADDR_WIDTH-1:0] waddr1_in,
   input  logic [DATA_WIDTH-1:0] wdata1_in,
   input  logic [ADDR_WIDTH-1:0] raddr1_in,
   input  logic [ADDR_WIDTH-1:0] raddr2_in,
   output logic [DATA_WIDTH-1:0] rdata1_out,
   output logic [DATA_WIDTH-1:0] rdata2_out,
   input  logic                  busy_set_in,
   input  logic [ADDR_WIDTH-1:0] busy_addr_in,
   output logic                  busy1_out,
   output logic                  busy2_out,
   output logic                  wconflict_out
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;
   logic                  wconflict_q;
   logic                  wconflict_d;

   logic we0_ok;
   logic we1_ok;
   logic bset_ok;

   // With a hardwired zero register, anything aimed at address 0 is dropped here.
   always_comb begin
      we0_ok      = we0_in;
      we1_ok      = we1_in;
      bset_ok     = busy_set_in;
      if (ZERO_REG != 0) begin
         if (waddr0_in == '0)    we0_ok  = 1'b0;
         if (waddr1_in == '0)    we1_ok  = 1'b0;
         if (busy_addr_in == '0) bset_ok = 1'b0;
      end
      wconflict_d = we0_ok && we1_ok && (waddr0_in == waddr1_in);
   end

   // Per-entry decode: port 1 has priority over port 0, and a busy set beats
   // the writeback clear because it marks a newer producer.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         logic hit0;
         logic hit1;
         logic hits;
         hit0 = we0_ok  && (waddr0_in    == ADDR_WIDTH'(i));
         hit1 = we1_ok  && (waddr1_in    == ADDR_WIDTH'(i));
         hits = bset_ok && (busy_addr_in == ADDR_WIDTH'(i));
         if (hit1)      mem_d[i] = wdata1_in;
         else if (hit0) mem_d[i] = wdata0_in;
         else           mem_d[i] = mem_q[i];
         busy_d[i] = hits | (busy_q[i] & ~(hit0 | hit1));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         busy_q      <= '0;
         wconflict_q <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         busy_q      <= busy_d;
         wconflict_q <= wconflict_d;
      end
   end

   assign wconflict_out = wconflict_q;

   // Two identical read ports; the later assignments in the block win, so the
   // zero rule outranks port 1 bypass, which outranks port 0 bypass.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd;
      logic                  bz;

      assign ra = (gi == 0) ? raddr1_in : raddr2_in;

      always_comb begin
         rd = mem_q[ra];
         bz = busy_q[ra];
         if (BYPASS != 0) begin
            if (we0_in && (waddr0_in == ra)) begin
               rd = wdata0_in;
               bz = 1'b0;
            end
            if (we1_in && (waddr1_in == ra)) begin
               rd = wdata1_in;
               bz = 1'b0;
            end
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
            bz = 1'b0;
         end
      end
   end

   assign rdata1_out = g_rd[0].rd;
   assign rdata2_out = g_rd[1].rd;
   assign busy1_out  = g_rd[0].bz;
   assign busy2_out  = g_rd[1].bz;

endmodule

// File: tb/tb_reg_file_2w_sb.sv
// Drives two register file variants (bypass + zero reg, and plain) with shared
// stimulus and compares both against a behavioural model.
module tb_reg_file_2w_sb;

   logic        clock = 1'b0;
   logic        reset;
   logic        we0, we1, bset;
   logic [4:0]  wa0, wa1, ra1, ra2, ba;
   logic [31:0] wd0, wd1;

   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic        a_bz1, a_bz2, b_bz1, b_bz2, a_wc, b_wc;

   int checks = 0;
   int errors = 0;

   // Model state: index 0 = bypass/zero-reg variant, 1 = plain variant.
   logic [31:0] m_reg  [2][32];
   bit          m_busy [2][32];
   bit          m_conf [2];

   always #5 clock = ~clock;

   reg_file_2w_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u_a (
      .clock(clock), .reset(reset),
      .we0_in(we0), .waddr0_in(wa0), .wdata0_in(wd0),
      .we1_in(we1), .waddr1_in(wa1), .wdata1_in(wd1),
      .raddr1_in(ra1), .raddr2_in(ra2), .rdata1_out(a_rd1), .rdata2_out(a_rd2),
      .busy_set_in(bset), .busy_addr_in(ba), .busy1_out(a_bz1), .busy2_out(a_bz2),
      .wconflict_out(a_wc)
   );

   reg_file_2w_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(0)) u_b (
      .clock(clock), .reset(reset),
      .we0_in(we0), .waddr0_in(wa0), .wdata0_in(wd0),
      .we1_in(we1), .waddr1_in(wa1), .wdata1_in(wd1),
      .raddr1_in(ra1), .raddr2_in(ra2), .rdata1_out(b_rd1), .rdata2_out(b_rd2),
      .busy_set_in(bset), .busy_addr_in(ba), .busy1_out(b_bz1), .busy2_out(b_bz2),
      .wconflict_out(b_wc)
   );

   function automatic logic [31:0] exp_rd(int k, logic [4:0] ra);
      if (k == 0 && ra == 5'd0) return 32'h0;
      if (k == 0 && we1 && wa1 == ra) return wd1;
      if (k == 0 && we0 && wa0 == ra) return wd0;
      return m_reg[k][ra];
   endfunction

   function automatic logic exp_bz(int k, logic [4:0] ra);
      if (k == 0 && ra == 5'd0) return 1'b0;
      if (k == 0 && ((we1 && wa1 == ra) || (we0 && wa0 == ra))) return 1'b0;
      return m_busy[k][ra];
   endfunction

   task automatic chk32(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk1(string tag, logic got, logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk32({tag, "_a_rd1"}, a_rd1, exp_rd(0, ra1));
      chk32({tag, "_a_rd2"}, a_rd2, exp_rd(0, ra2));
      chk1 ({tag, "_a_bz1"}, a_bz1, exp_bz(0, ra1));
      chk1 ({tag, "_a_bz2"}, a_bz2, exp_bz(0, ra2));
      chk1 ({tag, "_a_wc"},  a_wc,  m_conf[0]);
      chk32({tag, "_b_rd1"}, b_rd1, exp_rd(1, ra1));
      chk32({tag, "_b_rd2"}, b_rd2, exp_rd(1, ra2));
      chk1 ({tag, "_b_bz1"}, b_bz1, exp_bz(1, ra1));
      chk1 ({tag, "_b_bz2"}, b_bz2, exp_bz(1, ra2));
      chk1 ({tag, "_b_wc"},  b_wc,  m_conf[1]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_conf[k] = 1'b0;
         for (int r = 0; r < 32; r++) begin
            m_reg[k][r]  = 32'h0;
            m_busy[k][r] = 1'b0;
         end
      end
   endtask

   // Writes applied in port order so port 1 wins; busy set applied after clears.
   task automatic model_edge();
      if (!reset) return;
      for (int k = 0; k < 2; k++) begin
         bit zr, ok0, ok1, okb;
         zr  = (k == 0);
         ok0 = we0  && !(zr && wa0 == 5'd0);
         ok1 = we1  && !(zr && wa1 == 5'd0);
         okb = bset && !(zr && ba  == 5'd0);
         m_conf[k] = ok0 && ok1 && (wa0 == wa1);
         if (ok0) begin m_reg[k][wa0] = wd0; m_busy[k][wa0] = 1'b0; end
         if (ok1) begin m_reg[k][wa1] = wd1; m_busy[k][wa1] = 1'b0; end
         if (okb) m_busy[k][ba] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; bset = 0;
      wa0 = 0; wa1 = 0; ba = 0;
      wd0 = 0; wd1 = 0;
   endtask

   initial begin
      reset = 1'b0;
      idle();
      ra1 = 0; ra2 = 0;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b1;
      #1;

      // Basic write then read, and register 0 on the other port
      tick();
      we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra1 = 5; ra2 = 0;
      #1 check_all("w5_pre");
      tick();
      idle();
      #1;
      chk32("w5_a_rd1", a_rd1, 32'hDEADBEEF);
      chk32("w5_b_rd1", b_rd1, 32'hDEADBEEF);
      chk32("w5_a_rd2", a_rd2, 32'h0);
      check_all("w5_post");

      // Zero register ignores writes and busy sets
      we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; bset = 1; ba = 0; ra1 = 0;
      #1 check_all("z0_pre");
      chk32("z0_pre_a_rd1", a_rd1, 32'h0);
      tick();
      idle();
      #1;
      chk32("z0_a_rd1", a_rd1, 32'h0);
      chk1 ("z0_a_bz1", a_bz1, 1'b0);
      chk1 ("z0_a_wc",  a_wc,  1'b0);
      chk32("z0_b_rd1", b_rd1, 32'hFFFFFFFF);
      chk1 ("z0_b_bz1", b_bz1, 1'b1);

      // Bypass vs no bypass
      we1 = 1; wa1 = 7; wd1 = 32'h12345678; ra1 = 7;
      #1;
      chk32("byp_a_pre", a_rd1, 32'h12345678);
      chk32("byp_b_pre", b_rd1, 32'h0);
      check_all("byp_pre");
      tick();
      idle();
      #1;
      chk32("byp_b_post", b_rd1, 32'h12345678);
      chk32("byp_a_post", a_rd1, 32'h12345678);

      // Write conflict: port 1 wins, flag for one cycle
      we0 = 1; wa0 = 9; wd0 = 32'hAAAA0000;
      we1 = 1; wa1 = 9; wd1 = 32'h0000BBBB; ra1 = 9;
      #1 check_all("conf_pre");
      tick();
      idle();
      #1;
      chk32("conf_a_rd1", a_rd1, 32'h0000BBBB);
      chk32("conf_b_rd1", b_rd1, 32'h0000BBBB);
      chk1 ("conf_a_wc1", a_wc, 1'b1);
      chk1 ("conf_b_wc1", b_wc, 1'b1);
      tick();
      #1;
      chk1 ("conf_a_wc2", a_wc, 1'b0);
      chk1 ("conf_b_wc2", b_wc, 1'b0);

      // Scoreboard set / set-beats-clear / clear
      bset = 1; ba = 3; ra1 = 3;
      #1 check_all("sb1_pre");
      tick();
      idle();
      #1;
      chk1("sb1_a_bz1", a_bz1, 1'b1);
      bset = 1; ba = 3; we0 = 1; wa0 = 3; wd0 = 32'h33;
      #1;
      chk1("sb2_a_pre", a_bz1, 1'b0);
      chk1("sb2_b_pre", b_bz1, 1'b1);
      tick();
      idle();
      #1;
      chk1("sb2_a_bz1", a_bz1, 1'b1);
      chk1("sb2_b_bz1", b_bz1, 1'b1);
      we1 = 1; wa1 = 3; wd1 = 32'h44;
      tick();
      idle();
      #1;
      chk1("sb3_a_bz1", a_bz1, 1'b0);
      chk1("sb3_b_bz1", b_bz1, 1'b0);
      check_all("sb3_post");

      // Asynchronous reset mid-cycle, with a conflict flag already raised
      we0 = 1; wa0 = 12; wd0 = 32'h11111111;
      we1 = 1; wa1 = 12; wd1 = 32'hCAFEF00D; bset = 1; ba = 12;
      tick();
      we1 = 0; ra1 = 12; ra2 = 5;
      wd0 = 32'hCAFEF00D;
      #1;
      chk1("rst_wc_before", a_wc, 1'b1);
      reset = 1'b0;
      #1;
      model_reset();
      chk1 ("rst_a_wc",  a_wc,  1'b0);
      chk1 ("rst_b_wc",  b_wc,  1'b0);
      chk32("rst_a_rd2", a_rd2, 32'h0);
      chk32("rst_b_rd1", b_rd1, 32'h0);
      chk1 ("rst_b_bz1", b_bz1, 1'b0);
      chk1 ("rst_a_bz1", a_bz1, 1'b0);
      check_all("rst_mid");
      idle();
      #1;
      chk32("rst_a_rd1", a_rd1, 32'h0);
      tick();
      check_all("rst_held");
      reset = 1'b1;
      #1;
      tick();
      #1;
      chk32("rel_a_rd1", a_rd1, 32'h0);
      chk32("rel_b_rd1", b_rd1, 32'h0);
      chk1 ("rel_b_bz1", b_bz1, 1'b0);

      // Randomized traffic over a small address window to provoke collisions
      for (int n = 0; n < 400; n++) begin
         we0  = ($urandom_range(0, 1) == 1);
         we1  = ($urandom_range(0, 2) == 0);
         bset = ($urandom_range(0, 1) == 1);
         wa0  = 5'($urandom_range(0, 7));
         wa1  = 5'($urandom_range(0, 7));
         ba   = 5'($urandom_range(0, 7));
         ra1  = 5'($urandom_range(0, 7));
         ra2  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         wd0  = $urandom;
         wd1  = $urandom;
         #1 check_all("rnd");
         if ($urandom_range(0, 63) == 0) begin
            reset = 1'b0;
            #1;
            model_reset();
            check_all("rnd_rst");
            reset = 1'b1;
         end
         tick();
      end
      idle();
      #1 check_all("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_2w_sb.md
Name: reg_file_2w_sb

Overview:
- Parametrised successor to the team's single-write register file. Two write ports, two combinational read ports, optional same-cycle write-to-read bypass, optional hardwired zero register.
- Adds a per-register busy scoreboard: the issue stage sets a bit, and writeback clears it.
- Sits between decode/issue (reads, busy set) and the dual writeback paths of the pipelined core.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return array contents only
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never goes busy

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- we0_in  input  1  write enable, port 0
- waddr0_in  input  ADDR_WIDTH  write address, port 0
- wdata0_in  input  DATA_WIDTH  write data, port 0
- we1_in  input  1  write enable, port 1
- waddr1_in  input  ADDR_WIDTH  write address, port 1
- wdata1_in  input  DATA_WIDTH  write data, port 1
- raddr1_in  input  ADDR_WIDTH  read address 1
- raddr2_in  input  ADDR_WIDTH  read address 2
- rdata1_out  output  DATA_WIDTH  read data 1 (combinational)
- rdata2_out  output  DATA_WIDTH  read data 2 (combinational)
- busy_set_in  input  1  mark busy_addr_in as pending
- busy_addr_in  input  ADDR_WIDTH  register to mark pending
- busy1_out  output  1  pending status of raddr1_in (combinational)
- busy2_out  output  1  pending status of raddr2_in (combinational)
- wconflict_out  output  1  registered flag: both write ports hit the same address last cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0.
  - All busy bits cleared.
  - wconflict_out is 0.
  - rdata outputs reflect zeros, subject to bypass.
- Writes: on the rising edge, if weN_in=1, reg[waddrN_in] <= wdataN_in.
  - A write to an address already written that cycle uses the rule below.
- Both ports enabled on the same address:
  - Port 1 wins.
  - wconflict_out=1 on the following cycle, else 0.
  - This holds only for a non-zero address, or for any address when ZERO_REG=0.
- Reads: combinational, with priority order:
  - Zero rule: ZERO_REG=1 and raddr=0 → output 0.
  - Bypass from port 1: BYPASS=1, we1_in and waddr1_in==raddr → wdata1_in.
  - Bypass from port 0: BYPASS=1, we0_in and waddr0_in==raddr → wdata0_in.
  - Otherwise: array contents.
  - With BYPASS=0, new data is visible one cycle after the write edge.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - Set: busy_set_in=1 sets busy[busy_addr_in].
  - Clear: a write on either port clears busy[waddr].
  - Same cycle, set and clear on the same address: set wins, because a new producer was issued after the old one completed.
  - Setting an already-busy bit leaves it set.
  - Writing a non-busy register is legal and leaves it clear.
- busyN_out = busy[raddrN_in], with two exceptions:
  - It is 0 if ZERO_REG=1 and raddr=0.
  - When BYPASS=1, it is 0 if a same-cycle write targets that address, because the data is being supplied now.
- ZERO_REG=1:
  - Writes and busy sets to address 0 are dropped.
  - Address 0 never raises wconflict_out.
- Reset asserted mid-operation:
  - Overrides any in-flight write or busy set immediately.
  - No write takes effect on an edge while reset=0.

Test Plan:
- Reset, then we0 addr5 data 0xDEADBEEF → next cycle rdata1 (raddr1=5)=0xDEADBEEF. raddr2=0 gives rdata2=0.
- ZERO_REG=1: we0 addr0 data 0xFFFFFFFF, plus busy_set addr0 → rdata1 (raddr1=0)=0, busy1=0, wconflict_out=0.
- BYPASS=1: same cycle we1 addr7 data 0x12345678 with raddr1=7 → rdata1=0x12345678 before the edge.
  - Same case with BYPASS=0: old value 0 before the edge, 0x12345678 after.
- we0 addr9 0xAAAA0000 and we1 addr9 0x0000BBBB in the same cycle → reg9=0x0000BBBB, wconflict_out=1 for exactly one cycle.
- Scoreboard:
  - busy_set addr3 → busy1 (raddr1=3)=1.
  - Next cycle, busy_set addr3 plus we0 addr3 → busy1 stays 1.
  - Next cycle, we1 addr3 alone → busy1=0.
- Write addr12 0xCAFEF00D with busy set on addr12, then drop reset mid-cycle → rdata=0, busy=0, and wconflict_out=0 immediately.
  - After reset is released, addr12 reads 0.
